// File: rtl/onectr_seq_pkg.sv
// ----------------------------------------------------------------------------
// onectr_seq_pkg
// Shared types and constants for the onectr program sequencer:
//   - state_e   : sequencer FSM states
//   - instr_t   : 32-bit microinstruction layout
//   - dp_ctrl_t : bundle of datapath control fields driven by the sequencer
//   - NOP_CTRL  : hold pattern (JP to the current PC, no register write)
// The optional watchdog is enabled by the macro ONECTR_SEQ_WATCHDOG_EN.
// ----------------------------------------------------------------------------
package onectr_seq_pkg;

    localparam int INSTR_W = 32;

    // Instruction field bit positions.
    localparam int HALT_BIT = 31;
    localparam int JF_BIT   = 30;
    localparam int JP_BIT   = 29;
    localparam int OP_MSB   = 28;
    localparam int OP_LSB   = 26;
    localparam int WEN_BIT  = 25;
    localparam int WA_MSB   = 24;
    localparam int WA_LSB   = 21;
    localparam int RAA_MSB  = 20;
    localparam int RAA_LSB  = 17;
    localparam int RAB_MSB  = 16;
    localparam int RAB_LSB  = 13;
    localparam int SEL_MSB  = 12;
    localparam int SEL_LSB  = 9;
    localparam int RSVD_BIT = 8;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Member order matches the bit positions above, MSB first.
    typedef struct packed {
        logic       halt;
        logic       jf;
        logic       jp;
        logic [2:0] op;
        logic       wen;
        logic [3:0] wa;
        logic [3:0] raa;
        logic [3:0] rab;
        logic [3:0] sel;
        logic       rsvd;
        logic [7:0] imm;
    } instr_t;

    // Datapath control bundle; the jump target is the low PC bits of ctrl.
    typedef struct packed {
        logic [7:0] ctrl;
        logic [3:0] sel;
        logic       wen;
        logic [3:0] wa;
        logic [3:0] raa;
        logic [3:0] rab;
        logic [2:0] op;
        logic       jp;
        logic       jf;
    } dp_ctrl_t;

    // NOP field constants: no write, unconditional jump (target supplied
    // separately as the current PC), so the datapath holds its state.
    localparam logic NOP_WEN = 1'b0;
    localparam logic NOP_JP  = 1'b1;
    localparam logic NOP_JF  = 1'b0;

    localparam dp_ctrl_t NOP_CTRL = '{
        ctrl: 8'h00,
        sel:  4'h0,
        wen:  NOP_WEN,
        wa:   4'h0,
        raa:  4'h0,
        rab:  4'h0,
        op:   3'h0,
        jp:   NOP_JP,
        jf:   NOP_JF
    };

endpackage : onectr_seq_pkg

// File: rtl/onectr_seq_decode.sv
// ----------------------------------------------------------------------------
// onectr_seq_decode
// Purely combinational instruction decoder.
// Ports:
//   instr_i : raw 32-bit microinstruction from program memory
//   ctrl_o  : datapath control fields (Ctrl = IMM)
//   halt_o  : HALT flag, ends the run in the sequencer
// Bit 8 of the instruction is reserved and deliberately ignored.
// ----------------------------------------------------------------------------
module onectr_seq_decode
    import onectr_seq_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output dp_ctrl_t           ctrl_o,
    output logic               halt_o
);

    instr_t instr;
    logic   unused_rsvd;

    assign instr       = instr_t'(instr_i);
    assign unused_rsvd = instr.rsvd;

    always_comb begin
        ctrl_o.ctrl = instr.imm;
        ctrl_o.sel  = instr.sel;
        ctrl_o.wen  = instr.wen;
        ctrl_o.wa   = instr.wa;
        ctrl_o.raa  = instr.raa;
        ctrl_o.rab  = instr.rab;
        ctrl_o.op   = instr.op;
        // JP and JF are forwarded as-is; the datapath resolves the case
        // where both are set.
        ctrl_o.jp   = instr.jp;
        ctrl_o.jf   = instr.jf;
        halt_o      = instr.halt;
    end

endmodule : onectr_seq_decode

// File: rtl/onectr_sequencer.sv
// ----------------------------------------------------------------------------
// onectr_sequencer
// Program controller for the onectr_nomem ones-counter datapath. Fetches
// microinstructions from a synchronous program memory at the datapath PC,
// drives the decoded control fields, and returns a result to the host through
// a valid/ready handshake.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start_i           : run request (sampled in IDLE only)
//   busy_o            : high in INIT/FETCH/EXEC
//   res_valid_o/ready : result handshake; res_data_o, res_err_o stable in DONE
//   imem_rd_o/addr_o  : program memory read strobe / address (= dp_pc_i)
//   imem_data_i       : instruction, valid the cycle after imem_rd_o
//   dp_pc_i, dp_out_i : datapath PC and OutPort
//   Ctrl_o .. JumpAddress_o : datapath control fields
//
// Optional feature: define ONECTR_SEQ_WATCHDOG_EN to abort runs after
// MAX_CYCLES executed (non-HALT) instructions with res_err_o=1.
// ----------------------------------------------------------------------------
module onectr_sequencer
    import onectr_seq_pkg::*;
#(
    parameter int INPUTSIZE  = 64,
    parameter int PCSIZE     = 8,
    parameter int MAX_CYCLES = 1024,
    localparam int OUTW      = $clog2(INPUTSIZE + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic               busy_o,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [OUTW-1:0]    res_data_o,
    output logic               res_err_o,
    output logic               imem_rd_o,
    output logic [PCSIZE-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic [PCSIZE-1:0]  dp_pc_i,
    input  logic [OUTW-1:0]    dp_out_i,
    output logic [7:0]         Ctrl_o,
    output logic [3:0]         Sel_o,
    output logic               Wen_o,
    output logic [3:0]         WA_o,
    output logic [3:0]         RAA_o,
    output logic [3:0]         RAB_o,
    output logic [2:0]         Op_o,
    output logic               JP_o,
    output logic               JF_o,
    output logic [PCSIZE-1:0]  JumpAddress_o
);

    state_e          state_q, state_d;
    logic [OUTW-1:0] res_data_q, res_data_d;

    dp_ctrl_t        dec_ctrl;
    logic            dec_halt;
    dp_ctrl_t        dp_ctrl;

    onectr_seq_decode u_decode (
        .instr_i (imem_data_i),
        .ctrl_o  (dec_ctrl),
        .halt_o  (dec_halt)
    );

    logic exec_step;   // EXEC of a non-HALT instruction
    logic wd_abort;

    assign exec_step = (state_q == ST_EXEC) && !dec_halt;

`ifdef ONECTR_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(MAX_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            res_err_q, res_err_d;

    // The abort fires in the EXEC whose increment would bring the counter to
    // MAX_CYCLES, so exactly MAX_CYCLES EXECs happen before DONE.
    assign wd_abort = exec_step && (wd_cnt_q == WD_W'(MAX_CYCLES - 1));

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == ST_INIT) begin
            wd_cnt_d = '0;
        end else if (exec_step) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            res_err_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            res_err_q <= res_err_d;
        end
    end

    assign res_err_o = res_err_q;
`else
    assign wd_abort  = 1'b0;
    assign res_err_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state, result capture and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        res_data_d    = res_data_q;
`ifdef ONECTR_SEQ_WATCHDOG_EN
        res_err_d     = res_err_q;
`endif
        dp_ctrl       = NOP_CTRL;
        JumpAddress_o = dp_pc_i;
        imem_rd_o     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_INIT;
            end
            ST_INIT: begin
                JumpAddress_o = '0;
                state_d       = ST_FETCH;
            end
            ST_FETCH: begin
                imem_rd_o = 1'b1;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_halt) begin
                    res_data_d = dp_out_i;
`ifdef ONECTR_SEQ_WATCHDOG_EN
                    res_err_d  = 1'b0;
`endif
                    state_d    = ST_DONE;
                end else if (wd_abort) begin
                    res_data_d = '0;
`ifdef ONECTR_SEQ_WATCHDOG_EN
                    res_err_d  = 1'b1;
`endif
                    state_d    = ST_DONE;
                end else begin
                    dp_ctrl       = dec_ctrl;
                    JumpAddress_o = dec_ctrl.ctrl[PCSIZE-1:0];
                    state_d       = ST_FETCH;
                end
            end
            ST_DONE: begin
                if (res_ready_i) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the result register has a reset value because res_data_o is
        // visible to the host straight out of reset.
        if (rst) begin
            state_q    <= ST_IDLE;
            res_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            res_data_q <= res_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy_o      = (state_q == ST_INIT) || (state_q == ST_FETCH) ||
                         (state_q == ST_EXEC);
    assign res_valid_o = (state_q == ST_DONE);
    assign res_data_o  = res_data_q;
    assign imem_addr_o = dp_pc_i;

    assign Ctrl_o = dp_ctrl.ctrl;
    assign Sel_o  = dp_ctrl.sel;
    assign Wen_o  = dp_ctrl.wen;
    assign WA_o   = dp_ctrl.wa;
    assign RAA_o  = dp_ctrl.raa;
    assign RAB_o  = dp_ctrl.rab;
    assign Op_o   = dp_ctrl.op;
    assign JP_o   = dp_ctrl.jp;
    assign JF_o   = dp_ctrl.jf;

endmodule : onectr_sequencer
